// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake plus
// the operand/result bus to the function units.
interface alu_sequencer_if;
  logic        Instr_Valid;
  logic [15:0] Instr;
  logic        Instr_Ready;
  logic [3:0]  Opcode;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  Select;
  logic [7:0]  Unit_Result;
  logic        Unit_Flag;

  modport master (
    output Instr_Valid,
    output Instr,
    output Unit_Result,
    output Unit_Flag,
    input  Instr_Ready,
    input  Opcode,
    input  A,
    input  B,
    input  Select
  );

  modport slave (
    input  Instr_Valid,
    input  Instr,
    input  Unit_Result,
    input  Unit_Flag,
    output Instr_Ready,
    output Opcode,
    output A,
    output B,
    output Select
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue stage for the 8-bit ALU.
// Latches a word, drives the units, writes back.
module alu_sequencer (
  input  logic           Clk,
  input  logic           Reset,
  alu_sequencer_if.slave bus,
  input  logic           Load_En,
  input  logic [1:0]     Load_Addr,
  input  logic [7:0]     Load_Data,
  input  logic [1:0]     Reg_Addr,
  output logic [7:0]     Reg_Data,
  output logic [7:0]     Result,
  output logic           Flag,
  output logic           Done,
  output logic           Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] sel;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  localparam logic [2:0] SEL_NONE = 3'b111;

  state_e          state_q;
  state_e          state_d;
  instr_t          instr_q;
  instr_t          instr_d;
  logic [3:0][7:0] rf_q;
  logic [3:0][7:0] rf_d;
  logic [7:0]      result_q;
  logic [7:0]      result_d;
  logic            flag_q;
  logic            flag_d;
  logic            err_q;
  logic            err_d;

  logic            accept;
  logic            drive;
  logic            wb;
  logic            load_ok;
  logic            unused_rsv;

  // Reserved instruction bits are never latched.
  assign unused_rsv = ^bus.Instr[2:0];

  // Next state, handshake and completion pulse.
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    drive           = 1'b0;
    wb              = 1'b0;
    bus.Instr_Ready = 1'b0;
    Done            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.Instr_Ready = 1'b1;
        accept          = bus.Instr_Valid;
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        drive   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        drive   = 1'b1;
        wb      = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the word on accept; loads only in IDLE.
  always_comb begin
    instr_d = instr_q;
    if (accept) instr_d = instr_t'(bus.Instr[15:3]);
    load_ok = Load_En && (state_q == S_IDLE);
  end

  // Register file: direct load or writeback.
  always_comb begin
    rf_d = rf_q;
    if (load_ok) rf_d[Load_Addr] = Load_Data;
    if (wb) rf_d[instr_q.rd] = bus.Unit_Result;
  end

  // Capture unit outputs at the end of WAIT.
  always_comb begin
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    if (wb) begin
      result_d = bus.Unit_Result;
      flag_d   = bus.Unit_Flag;
      if (!bus.Unit_Flag) err_d = 1'b1;
    end
  end

  // Operands come from the live regfile so an
  // IDLE load is seen by the accepted word.
  always_comb begin
    bus.Opcode = 4'h0;
    bus.A      = 8'h00;
    bus.B      = 8'h00;
    bus.Select = SEL_NONE;
    if (drive) begin
      bus.Opcode = instr_q.op;
      bus.A      = rf_q[instr_q.rs1];
      bus.B      = rf_q[instr_q.rs2];
      bus.Select = instr_q.sel;
    end
  end

  // Status and debug read.
  always_comb begin
    Reg_Data = rf_q[Reg_Addr];
    Result   = result_q;
    Flag     = flag_q;
    Err      = err_q;
  end

  // All state; reset abandons any instruction.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      rf_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rf_q     <= rf_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: vector table, corner sequences
// and random words against a regfile model.
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load_En = 1'b0;
  logic [1:0] Load_Addr = 2'd0;
  logic [7:0] Load_Data = 8'h00;
  logic [1:0] Reg_Addr = 2'd0;
  logic [7:0] Reg_Data;
  logic [7:0] Result;
  logic       Flag;
  logic       Done;
  logic       Err;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Load_En   (Load_En),
    .Load_Addr (Load_Addr),
    .Load_Data (Load_Data),
    .Reg_Addr  (Reg_Addr),
    .Reg_Data  (Reg_Data),
    .Result    (Result),
    .Flag      (Flag),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_rf [4];
  logic       m_err;

  logic [7:0] ures;
  logic       uflag;

  // Unit 000 implements AND/OR/XOR/ADD; all else
  // reports not-executed.
  function automatic logic [8:0] unit_fn(
    logic [3:0] op, logic [2:0] sel,
    logic [7:0] a, logic [7:0] b);
    logic [7:0] s;
    logic [8:0] r;
    s = a + b;
    r = '0;
    if (sel == 3'b000) begin
      case (op)
        4'd0: r = {1'b1, a & b};
        4'd1: r = {1'b1, a | b};
        4'd2: r = {1'b1, a ^ b};
        4'd3: r = {1'b1, s};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Registered function units.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ures  <= '0;
      uflag <= 1'b0;
    end else begin
      {uflag, ures} <= unit_fn(bus.Opcode,
        bus.Select, bus.A, bus.B);
    end
  end

  assign bus.Unit_Result = ures;
  assign bus.Unit_Flag   = uflag;

  task automatic chk(string name,
    logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
        name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_err = 1'b0;
  endtask

  task automatic model_exec(
    input logic [15:0] w, input logic ld,
    input logic [1:0] la, input logic [7:0] ldd,
    output logic [7:0] ea, output logic [7:0] eb,
    output logic [7:0] er, output logic ef);
    logic [8:0] u;
    if (ld) m_rf[la] = ldd;
    ea = m_rf[w[6:5]];
    eb = m_rf[w[4:3]];
    u = unit_fn(w[15:12], w[11:9], ea, eb);
    {ef, er} = u;
    m_rf[w[8:7]] = er;
    if (!ef) m_err = 1'b1;
  endtask

  // Starts and ends at a negedge in IDLE.
  task automatic run_instr(
    input logic [15:0] w, input logic ld,
    input logic [1:0] la, input logic [7:0] ldd,
    input logic [7:0] ea, input logic [7:0] eb,
    input logic [7:0] er, input logic ef,
    input logic ee);
    chk("ready_idle", bus.Instr_Ready, 1);
    bus.Instr_Valid = 1'b1;
    bus.Instr = w;
    Load_En = ld;
    Load_Addr = la;
    Load_Data = ldd;
    @(negedge Clk);
    bus.Instr_Valid = 1'b0;
    Load_En = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) @(negedge Clk);
      chk("sel", bus.Select, w[11:9]);
      chk("opcode", bus.Opcode, w[15:12]);
      chk("A", bus.A, ea);
      chk("B", bus.B, eb);
      chk("ready_busy", bus.Instr_Ready, 0);
      chk("done_early", Done, 0);
    end
    @(negedge Clk);
    Reg_Addr = w[8:7];
    #1;
    chk("done", Done, 1);
    chk("result", Result, er);
    chk("flag", Flag, ef);
    chk("err", Err, ee);
    chk("rd_wb", Reg_Data, er);
    chk("sel_done", bus.Select, 3'b111);
    @(negedge Clk);
    chk("done_clear", Done, 0);
  endtask

  task automatic do_load(input logic [1:0] a,
    input logic [7:0] d);
    Load_En = 1'b1;
    Load_Addr = a;
    Load_Data = d;
    @(negedge Clk);
    Load_En = 1'b0;
    m_rf[a] = d;
  endtask

  typedef struct {
    logic [15:0] w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  r;
    logic        f;
    logic        e;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea, eb, er, er1, er2, r1b;
    logic ef, ef1, ef2;
    logic [15:0] w, w1, w2;
    logic ld;
    logic [1:0] la;
    logic [7:0] ldd;
    int ndone;

    tbl[0] = '{16'h0108, 8'hF0, 8'h3C, 8'h30, 1, 0};
    tbl[1] = '{16'h1188, 8'hF0, 8'h3C, 8'hFC, 1, 0};
    tbl[2] = '{16'h2077, 8'hFC, 8'h30, 8'hCC, 1, 0};
    tbl[3] = '{16'h3088, 8'hCC, 8'h3C, 8'h08, 1, 0};
    tbl[4] = '{16'h5108, 8'hCC, 8'h08, 8'h00, 0, 1};
    tbl[5] = '{16'h0108, 8'hCC, 8'h08, 8'h08, 1, 1};
    tbl[6] = '{16'h0308, 8'hCC, 8'h08, 8'h00, 0, 1};
    tbl[7] = '{16'h3000, 8'hCC, 8'hCC, 8'h98, 1, 1};

    bus.Instr_Valid = 1'b0;
    bus.Instr = 16'h0000;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_ready", bus.Instr_Ready, 1);
    chk("rst_sel", bus.Select, 3'b111);
    chk("rst_opcode", bus.Opcode, 0);
    chk("rst_A", bus.A, 0);
    chk("rst_B", bus.B, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_flag", Flag, 0);
    chk("rst_err", Err, 0);
    Reset = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 10; i++) begin
      chk("idle_sel", bus.Select, 3'b111);
      chk("idle_opcode", bus.Opcode, 0);
      chk("idle_A", bus.A, 0);
      chk("idle_B", bus.B, 0);
      chk("idle_done", Done, 0);
      @(negedge Clk);
    end

    do_load(2'd0, 8'hF0);
    do_load(2'd1, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      model_exec(tbl[i].w, 0, 0, 0, ea, eb, er, ef);
      run_instr(tbl[i].w, 0, 0, 0, tbl[i].a,
        tbl[i].b, tbl[i].r, tbl[i].f, tbl[i].e);
    end

    // Load during WAIT is ignored.
    r1b = m_rf[1];
    w = 16'h1188;
    model_exec(w, 0, 0, 0, ea, eb, er, ef);
    bus.Instr_Valid = 1'b1;
    bus.Instr = w;
    @(negedge Clk);
    bus.Instr_Valid = 1'b0;
    @(negedge Clk);
    Load_En = 1'b1;
    Load_Addr = 2'd1;
    Load_Data = 8'hAA;
    @(negedge Clk);
    Load_En = 1'b0;
    chk("gate_done", Done, 1);
    @(negedge Clk);
    Reg_Addr = 2'd1;
    #1;
    chk("gate_r1", Reg_Data, r1b);

    // Load with accept in IDLE is seen as A.
    w = 16'h0138;
    model_exec(w, 1, 2'd1, 8'hAA, ea, eb, er, ef);
    run_instr(w, 1, 2'd1, 8'hAA, ea, eb, er, ef,
      m_err);

    // Back-to-back words under held valid.
    w1 = 16'h2070;
    w2 = 16'h1188;
    model_exec(w1, 0, 0, 0, ea, eb, er1, ef1);
    model_exec(w2, 0, 0, 0, ea, eb, er2, ef2);
    ndone = 0;
    bus.Instr_Valid = 1'b1;
    bus.Instr = w1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge Clk);
      chk($sformatf("bp_ready_c%0d", c),
        bus.Instr_Ready, (c % 4) == 0);
      chk($sformatf("bp_done_c%0d", c),
        Done, (c % 4) == 3);
      if (Done) ndone++;
      if (c == 3) chk("bp_res1", Result, er1);
      if (c == 7) chk("bp_res2", Result, er2);
      if (c == 1) bus.Instr = w2;
      if (c == 8) bus.Instr_Valid = 1'b0;
    end
    chk("bp_ndone", ndone, 2);
    @(negedge Clk);

    // Reset in WAIT abandons the instruction.
    chk("pre_rst_err", Err, m_err);
    bus.Instr_Valid = 1'b1;
    bus.Instr = 16'h0508;
    @(negedge Clk);
    bus.Instr_Valid = 1'b0;
    @(negedge Clk);
    chk("mid_sel_wait", bus.Select, 3'b010);
    Reset = 1'b0;
    model_reset();
    #1;
    chk("mid_sel", bus.Select, 3'b111);
    chk("mid_ready", bus.Instr_Ready, 1);
    chk("mid_opcode", bus.Opcode, 0);
    chk("mid_A", bus.A, 0);
    chk("mid_done", Done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("mid_no_done", Done, 0);
    end
    Reset = 1'b1;
    @(negedge Clk);
    chk("post_done", Done, 0);
    for (int r = 0; r < 4; r++) begin
      Reg_Addr = 2'(r);
      #1;
      chk($sformatf("post_r%0d", r), Reg_Data, 0);
    end
    chk("post_result", Result, 0);
    chk("post_flag", Flag, 0);
    chk("post_err", Err, 0);

    // Random words against the model.
    for (int i = 0; i < 40; i++) begin
      w[15:12] = 4'($urandom_range(0, 7));
      w[11:9] = ($urandom_range(0, 3) == 0) ?
        3'($urandom_range(1, 6)) : 3'b000;
      w[8:0] = 9'($urandom);
      ld = 1'($urandom);
      la = 2'($urandom);
      ldd = 8'($urandom);
      model_exec(w, ld, la, ldd, ea, eb, er, ef);
      run_instr(w, ld, la, ldd, ea, eb, er, ef,
        m_err);
    end
    for (int r = 0; r < 4; r++) begin
      Reg_Addr = 2'(r);
      #1;
      chk($sformatf("final_r%0d", r), Reg_Data,
        m_rf[r]);
    end

    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Front-end issue stage for the 8-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads two operands from an internal 4×8 register file. It drives Opcode/A/B/Select to the registered function units (Transfer, etc.) and captures their Result/Flag one cycle later. It then writes the result back to the register file and reports completion.

## Interface
- No parameters; all widths fixed (8-bit data, 4 registers, 4-bit opcode, 3-bit unit select).
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr_Valid  in  1  instruction word present.
- Instr  in  16  [15:12] opcode, [11:9] unit select, [8:7] rd, [6:5] rs1, [4:3] rs2, [2:0] reserved (ignored).
- Instr_Ready  out  1  high only in IDLE.
- Load_En  in  1  direct register-file write request.
- Load_Addr  in  2  register index for Load_En.
- Load_Data  in  8  data for Load_En.
- Reg_Addr  in  2  debug read index.
- Reg_Data  out  8  combinational read of register Reg_Addr.
- Opcode  out  4  to function units.
- A, B  out  8 each  operand values regfile[rs1], regfile[rs2].
- Select  out  3  unit select; 3'b111 = no unit (idle code).
- Unit_Result  in  8  OR of function-unit results.
- Unit_Flag  in  1  OR of function-unit flags; 1 = opcode executed.
- Result  out  8  last captured Unit_Result.
- Flag  out  1  last captured Unit_Flag.
- Done  out  1  one-cycle pulse per completed instruction.
- Err  out  1  sticky; set when a captured Unit_Flag is 0.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE: Instr_Ready=1. On Instr_Valid&Instr_Ready, latch Instr into an internal register and go to ISSUE.
- ISSUE: drive Opcode, Select, A=regfile[rs1], B=regfile[rs2] from the latched word; go to WAIT.
- WAIT: hold Opcode/Select/A/B unchanged, so the units see stable inputs across their capture edge. At the end of WAIT:
  - capture Unit_Result→Result and Unit_Flag→Flag;
  - write Unit_Result to regfile[rd];
  - if Unit_Flag==0, set Err;
  - go to DONE.
- DONE: Done=1; go to IDLE.
- Outside ISSUE/WAIT: Opcode=4'b0000, A=B=8'h00, Select=3'b111.
- Load_En is honoured only in IDLE; it writes regfile[Load_Addr] at the edge. In any other state it is silently ignored.
- Load and instruction acceptance in the same IDLE cycle: both take effect. The instruction reads the newly loaded value, because operands are read in ISSUE.
- rd may equal rs1/rs2. The operands are read before writeback, so no hazard exists.
- Reserved bits [2:0] have no effect.
- Err is cleared only by Reset.

## Timing
- Accept edge = end of cycle 0. ISSUE = cycle 1. WAIT = cycle 2 (Unit_Result valid). DONE = cycle 3 (Done high; Result/Flag/regfile updated). Instr_Ready high again in cycle 4.
- Latency: 3 cycles from accept to Done. Throughput: 1 instruction per 4 cycles.
- While Instr_Valid is held through cycles 1–3, Instr_Ready=0 and nothing new is accepted. A new accept can occur at the end of cycle 4.
- Reset low (any time, asynchronous):
  - FSM returns to IDLE and all registers clear to 0, including the regfile and the latched instruction;
  - Result=0, Flag=0, Done=0, Err=0, Opcode=0, A=B=0, Select=3'b111, Instr_Ready=1.
- Reset mid-instruction (ISSUE/WAIT): the instruction is abandoned, with no writeback and no Done.
- Reg_Data reflects a write starting the cycle after the write edge.

## Test plan
- Basic AND via Transfer unit: load r0=8'hF0, r1=8'h3C; issue Instr=16'h0108 (opcode 0000, sel 000, rd=2, rs1=0, rs2=1) -> in cycles 1–2: A=F0, B=3C, Select=000; in cycle 3: Done=1, Result=8'h30, Flag=1; Reg_Data(r2)=8'h30; Err=0.
- Unsupported opcode: Instr=16'h5108 (opcode 0101, sel 000) -> Result=0, Flag=0, r2=0, Err=1 and stays 1 through later good instructions.
- Backpressure: hold Instr_Valid high for 8 cycles with two different words -> Instr_Ready low in cycles 1–3; second word accepted only at the end of cycle 4; exactly two Done pulses, 4 cycles apart.
- Load gating: Load_En (addr 1, data 8'hAA) asserted during WAIT -> r1 unchanged. Same load asserted in IDLE together with an instruction using rs1=1 -> A=8'hAA in ISSUE.
- Reset mid-WAIT: drop Reset during cycle 2 -> immediately Select=3'b111 and Instr_Ready=1; no Done; all registers read 0 after release.
- Idle outputs: no traffic for 10 cycles -> Select=3'b111, Opcode=0, A=B=0, Done=0 throughout.
